// File: rtl/random_block_loader.sv
`default_nettype none
// ============================================================================
// Module   : random_block_loader
// Brief    : Captures DEPTH generator words (upper OUT_WIDTH bits) and streams
//            them out as one valid/ready block with last-marking.
// Revision : 1.0 - initial release
// ============================================================================
module random_block_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  rnd_en_o,
    input  logic [DATA_WIDTH-1:0] rnd_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [OUT_WIDTH-1:0]  out_data_o,
    output logic [ADDR_WIDTH-1:0] out_index_o,
    output logic                  out_last_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        FLUSH  = 2'd2,
        STREAM = 2'd3
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  fill_cnt_q, fill_cnt_d;
    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic                   en_q;
    logic                   done_q, done_d;
    logic [OUT_WIDTH-1:0]   buffer_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fill_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            en_q       <= rnd_en_o;
            done_q     <= done_d;
        end
    end

    // The generator word lags its enable by one cycle, hence capture on en_q.
    always_ff @(posedge clk) begin
        if (en_q) begin
            buffer_q[wr_ptr_q] <= rnd_i[DATA_WIDTH-1 -: OUT_WIDTH];
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        done_d      = 1'b0;
        busy_o      = 1'b1;
        rnd_en_o    = 1'b0;
        out_valid_o = 1'b0;

        if (en_q) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end

        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_d    = FILL;
                    fill_cnt_d = '0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                end
            end
            FILL: begin
                rnd_en_o   = 1'b1;
                fill_cnt_d = fill_cnt_q + ONE;
                if (fill_cnt_q == LAST_IDX) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = STREAM;
            end
            STREAM: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    rd_ptr_d = rd_ptr_q + ONE;
                    if (rd_ptr_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Data/index are forced to zero outside STREAM so reset and idle are clean.
    assign out_data_o  = out_valid_o ? buffer_q[rd_ptr_q] : '0;
    assign out_index_o = out_valid_o ? rd_ptr_q : '0;
    assign out_last_o  = out_valid_o && (rd_ptr_q == LAST_IDX);
    assign done_o      = done_q;

    generate
        if (OUT_WIDTH < DATA_WIDTH) begin : g_unused_low
            logic unused_low_bits;
            assign unused_low_bits = ^rnd_i[DATA_WIDTH-OUT_WIDTH-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_random_block_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_random_block_loader
// Brief    : Scoreboard bench for random_block_loader with a generator model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_random_block_loader;

    localparam int DW    = 32;
    localparam int OW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] rnd = '0;
    logic          busy, rnd_en, out_valid, out_last, done;
    logic [OW-1:0] out_data;
    logic [AW-1:0] out_index;

    int checks = 0;
    int failures = 0;
    int gen_k = 0;
    logic [OW-1:0] sb [$];

    random_block_loader #(
        .DATA_WIDTH(DW), .OUT_WIDTH(OW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy),
        .rnd_en_o(rnd_en), .rnd_i(rnd), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data),
        .out_index_o(out_index), .out_last_o(out_last), .done_o(done)
    );

    always #5 clk = ~clk;

    // Generator model: the k-th enabled edge produces k * 0x1000_0000.
    always @(posedge clk) begin
        if (rnd_en === 1'b1) begin
            logic [DW-1:0] v;
            gen_k++;
            v = {gen_k[3:0], 28'h0};
            rnd <= v;
            sb.push_back(v[DW-1 -: OW]);
        end
    end

    task automatic fill_phase(input bit poke, input bit already_started);
        int en_cnt = 0;
        if (!already_started) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int c = 0; c <= DEPTH; c++) begin
            if (rnd_en === 1'b1) en_cnt++;
            checks++;
            if (rnd_en !== (c < DEPTH)) begin
                failures++;
                $display("FAIL fill_rnd_en cycle=%0d got=%b exp=%b", c, rnd_en, (c < DEPTH));
            end
            checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL fill_ctl cycle=%0d busy=%b valid=%b exp busy=1 valid=0", c, busy, out_valid);
            end
            start = (poke && c == 3);
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (en_cnt != DEPTH) begin
            failures++;
            $display("FAIL fill_en_count got=%0d exp=%0d", en_cnt, DEPTH);
        end
        checks++;
        if (sb.size() != DEPTH) begin
            failures++;
            $display("FAIL fill_sb_size got=%0d exp=%0d", sb.size(), DEPTH);
        end
    endtask

    task automatic drain_block(input int mode, input int stop_after, input bit poke,
                               input bit start_in_done);
        int n = 0;
        int cyc = 0;
        while (n < stop_after && cyc < 64) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            start = (poke && cyc == 2);
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL stream_ctl cyc=%0d valid=%b busy=%b done=%b exp 1/1/0", cyc, out_valid, busy, done);
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL stream_sb_empty cyc=%0d got data=%h exp none", cyc, out_data);
            end else if (out_data !== sb[0] || out_index !== n[AW-1:0] || out_last !== (n == DEPTH - 1)) begin
                failures++;
                $display("FAIL stream_elem n=%0d got data=%h idx=%0d last=%b exp data=%h idx=%0d last=%b",
                         n, out_data, out_index, out_last, sb[0], n, (n == DEPTH - 1));
            end
            if (out_ready) begin
                if (sb.size() > 0) void'(sb.pop_front());
                n++;
            end
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        start = 1'b0;
        checks++;
        if (n != stop_after) begin
            failures++;
            $display("FAIL stream_timeout got=%0d exp=%0d transfers", n, stop_after);
        end
        if (stop_after == DEPTH) begin
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || sb.size() != 0) begin
                failures++;
                $display("FAIL done_pulse done=%b busy=%b valid=%b left=%0d exp 1/0/0/0", done, busy, out_valid, sb.size());
            end
            if (start_in_done) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (!start_in_done) begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b0 || rnd_en !== 1'b0) begin
                    failures++;
                    $display("FAIL post_done_idle done=%b busy=%b rnd_en=%b exp 0/0/0", done, busy, rnd_en);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, rnd_en, out_valid, out_last, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctl got busy=%b en=%b valid=%b last=%b done=%b exp all 0",
                     busy, rnd_en, out_valid, out_last, done);
        end
        checks++;
        if (out_data !== '0 || out_index !== '0) begin
            failures++;
            $display("FAIL reset_data got data=%h idx=%0d exp 0/0", out_data, out_index);
        end
        start = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rnd_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b en=%b exp 0/0", busy, rnd_en);
        end
    endtask

    task automatic test_capture();
        fill_phase(1'b0, 1'b0);
        checks++;
        if (out_data !== 16'h1000 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL first_word got=%h valid=%b exp=1000 valid=1", out_data, out_valid);
        end
        drain_block(0, DEPTH, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        fill_phase(1'b0, 1'b0);
        drain_block(1, DEPTH, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_start();
        fill_phase(1'b1, 1'b0);
        drain_block(0, DEPTH, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rnd_en !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL ignored_start busy=%b en=%b pushed=%0d exp 0/0/0", busy, rnd_en, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        fill_phase(1'b0, 1'b0);
        drain_block(0, DEPTH, 1'b0, 1'b1);
        fill_phase(1'b0, 1'b1);
        drain_block(0, DEPTH, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        fill_phase(1'b0, 1'b0);
        drain_block(0, 3, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, rnd_en, out_valid, out_last, done} !== 5'b0 || out_data !== '0 || out_index !== '0) begin
            failures++;
            $display("FAIL reset_mid_stream busy=%b en=%b valid=%b last=%b done=%b data=%h idx=%0d exp all 0",
                     busy, rnd_en, out_valid, out_last, done, out_data, out_index);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        fill_phase(1'b0, 1'b0);
        drain_block(0, DEPTH, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_capture();
        test_backpressure();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
